// File: rtl/ntt_layer_ctrl_pkg.sv
// Shared constants and types for the Kyber NTT layer sequencer.
// Imported by the address generator and the controller.
package ntt_layer_ctrl_pkg;

  localparam int N            = 256;
  localparam int LOG_N        = 8;
  localparam int NUM_LAYERS   = 7;
  localparam int Q            = 3329;
  localparam int BF_PER_LAYER = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
  } rd_req_t;

endpackage

// File: rtl/ntt_layer_ctrl_if.sv
// Control/status and RAM-side bus of the NTT layer sequencer.
// master = requester, slave = sequencer.
interface ntt_layer_ctrl_if;

  logic       start;
  logic       inverse;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] zeta_idx;
  logic       bf_valid;
  logic       bf_inv;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;
  logic [2:0] layer;

  modport master (
    output start, inverse,
    input  busy, done, rd_en,
    input  rd_addr_a, rd_addr_b, zeta_idx,
    input  bf_valid, bf_inv, wr_en,
    input  wr_addr_a, wr_addr_b, layer
  );

  modport slave (
    input  start, inverse,
    output busy, done, rd_en,
    output rd_addr_a, rd_addr_b, zeta_idx,
    output bf_valid, bf_inv, wr_en,
    output wr_addr_a, wr_addr_b, layer
  );

endinterface

// File: rtl/ntt_addr_gen.sv
// Butterfly address and zeta index for (layer, idx, mode).
// Purely combinational.
module ntt_addr_gen
  import ntt_layer_ctrl_pkg::*;
(
  input  logic [2:0] layer_i,
  input  logic [6:0] idx_i,
  input  logic       inverse_i,
  output logic [7:0] addr_a_o,
  output logic [7:0] addr_b_o,
  output logic [6:0] zeta_idx_o
);

  logic [7:0] len;
  logic [2:0] lg;
  logic [6:0] mask;
  logic [6:0] grp;
  logic [6:0] off;

  always_comb begin
    if (inverse_i) begin
      lg  = layer_i + 3'd1;
      len = 8'd2 << layer_i;
    end else begin
      lg  = 3'd7 - layer_i;
      len = 8'd128 >> layer_i;
    end
    mask     = 7'(len - 8'd1);
    grp      = idx_i >> lg;
    off      = idx_i & mask;
    // group base is grp * 2 * len
    addr_a_o = (({1'b0, grp} << lg) << 1) + {1'b0, off};
    addr_b_o = addr_a_o + len;
    if (inverse_i) begin
      zeta_idx_o = 7'((8'd128 >> layer_i) - 8'd1) - grp;
    end else begin
      zeta_idx_o = (7'd1 << layer_i) + grp;
    end
  end

endmodule

// File: rtl/ntt_layer_ctrl.sv
// Seven-layer NTT/INTT butterfly sequencer with
// delay-matched write-back and inter-layer drain.
module ntt_layer_ctrl
  import ntt_layer_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input logic             clk,
  input logic             rst_n,
  ntt_layer_ctrl_if.slave bus
);

  localparam int DRAIN = RD_LAT + BF_LAT;

  state_e     state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [2:0] layer_q, layer_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       inv_q, inv_d;

  logic [7:0] gen_a, gen_b;
  logic [6:0] gen_z;
  logic       issue;
  rd_req_t    rd_req;
  rd_req_t    dly_q [DRAIN];

  ntt_addr_gen u_addr_gen (
    .layer_i    (layer_q),
    .idx_i      (idx_q),
    .inverse_i  (inv_q),
    .addr_a_o   (gen_a),
    .addr_b_o   (gen_b),
    .zeta_idx_o (gen_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      layer_q <= '0;
      dcnt_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      layer_q <= layer_d;
      dcnt_q  <= dcnt_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    layer_d = layer_q;
    dcnt_d  = dcnt_q;
    inv_d   = inv_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          inv_d   = bus.inverse;
          layer_d = '0;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        idx_d = idx_q + 7'd1;
        if (idx_q == 7'd127) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 8'd1;
        if (dcnt_q == 8'(DRAIN - 1)) begin
          if (layer_q == 3'd6) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + 3'd1;
            idx_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // addresses are forced to zero outside ISSUE so idle buses stay quiet
  always_comb begin
    issue     = (state_q == S_ISSUE);
    rd_req.en = issue;
    rd_req.a  = issue ? gen_a : 8'd0;
    rd_req.b  = issue ? gen_b : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DRAIN; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= rd_req;
      for (int i = 1; i < DRAIN; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = rd_req.en;
  assign bus.rd_addr_a = rd_req.a;
  assign bus.rd_addr_b = rd_req.b;
  assign bus.zeta_idx  = issue ? gen_z : 7'd0;
  assign bus.bf_valid  = dly_q[RD_LAT-1].en;
  assign bus.bf_inv    = inv_q;
  assign bus.wr_en     = dly_q[DRAIN-1].en;
  assign bus.wr_addr_a = dly_q[DRAIN-1].a;
  assign bus.wr_addr_b = dly_q[DRAIN-1].b;
  assign bus.layer     = layer_q;

endmodule

// File: doc/ntt_layer_ctrl.md
Name: ntt_layer_ctrl

Overview:
Sequencer for one in-place 256-point Kyber (q=3329) NTT or inverse NTT over a dual-port coefficient RAM. It walks all 7 layers and issues one butterfly per cycle: two read addresses, a zeta ROM index and a CT/GS mode flag. Write-back addresses are delay-matched to the butterfly datapath (Mod_mul plus Mod_add/Mod_sub). The pipeline drains between layers, so no RAW hazard reaches the RAM.

Parameters:
RD_LAT, 1, cycles from rd_en to RAM/zeta-ROM data valid
BF_LAT, 3, cycles from butterfly input valid to result valid
(DRAIN = RD_LAT+BF_LAT is derived, not a parameter)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE
inverse  in  1  0=forward NTT (CT), 1=inverse (GS); sampled with accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the final write-back has been issued
rd_en  out  1  coefficient RAM read strobe (both ports)
rd_addr_a  out  8  port A read address (j)
rd_addr_b  out  8  port B read address (j+len)
zeta_idx  out  7  zeta ROM index, aligned with rd_en
bf_valid  out  1  butterfly input valid = rd_en delayed RD_LAT
bf_inv  out  1  latched mode, constant during an operation
wr_en  out  1  write strobe = rd_en delayed DRAIN
wr_addr_a  out  8  rd_addr_a delayed DRAIN
wr_addr_b  out  8  rd_addr_b delayed DRAIN
layer  out  3  current layer 0..6 (debug/status)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, all delay lines cleared, counters 0. Takes effect immediately, mid-operation included; no write-back completes after reset.
- FSM states:
  - IDLE: start=1 latches inverse, clears layer and idx, goes to ISSUE.
  - ISSUE: rd_en=1 every cycle, idx 0..127. At idx=127 goes to DRAIN.
  - DRAIN: counts DRAIN cycles. On the last drain cycle: if layer=6 goes to DONE, else layer+1, idx=0, back to ISSUE.
  - DONE: done=1 for one cycle, then IDLE.
- Layer length:
  - forward: len = 128>>layer
  - inverse: len = 2<<layer
  - group g = idx>>log2(len); off = idx & (len-1)
- Addresses: rd_addr_a = g*2*len + off; rd_addr_b = rd_addr_a + len. All arithmetic is 8-bit unsigned; no wrap occurs by construction.
- Zeta index:
  - forward: zeta_idx = (1<<layer) + g, range 1..127
  - inverse: zeta_idx = (128>>layer) - 1 - g, range 127..1
- Timing with default params (DRAIN=4), start accepted at cycle 0:
  - layer L reads at cycles 132L+1 .. 132L+128
  - last write of layer L at cycle 132L+132; the next layer reads from the following cycle (RAM is write-then-read safe)
  - last write at cycle 924; done at cycle 925; busy high cycles 1..925
- Exactly 896 rd_en and 896 wr_en pulses per operation.
- start while busy: ignored, no effect on sequence or mode. inverse changes mid-operation: ignored.
- Final 1/128 scaling of the inverse NTT is not done here (handled downstream).

Decomposition:
- Shared package: N=256, LOG_N=8, NUM_LAYERS=7, Q=3329, BF_PER_LAYER=128, FSM state encodings.
- Sub-module ntt_addr_gen: combinational (layer, idx, inverse) -> (addr_a, addr_b, zeta_idx).
- Delay lines, FSM and counters stay in ntt_layer_ctrl.

Test Plan:
- Forward start at cycle 0 -> cycle 1: rd_addr_a=0, rd_addr_b=128, zeta_idx=1. Cycle 128: a=127, b=255, zeta_idx=1. Cycle 2: bf_valid=1. Cycle 5: wr_en=1, wr_addr_a=0, wr_addr_b=128.
- Forward layer 6: first read a=0, b=2, zeta_idx=64; last read (cycle 920) a=253, b=255, zeta_idx=127. done=1 at cycle 925 only; total 896 wr_en; busy=0 from cycle 926.
- Inverse start -> layer 0 first read a=0, b=2, zeta_idx=127; layer 6 first read a=0, b=128, zeta_idx=1; bf_inv=1 throughout.
- Pulse start at cycles 50 and 400 during a forward operation -> sequence identical to the undisturbed run; single done at 925.
- Drop rst_n at cycle 300 -> all outputs 0 in the same cycle; no wr_en afterwards. Restart -> exact cycle-1 sequence of scenario 1.
- Checker runs a Python/golden model of the Kyber NTT over RAM plus Mod_add/Mod_sub -> RAM contents after done match for 10 random polynomials in each mode.
